// File: rtl/captura_clave_teclado_pkg.sv
// Shared definitions for the keypad PIN capture stage and the access controller:
// key codes, PIN geometry and the capture FSM state encoding.
package captura_clave_teclado_pkg;

   localparam int TECLA_W     = 4;
   localparam int CLAVE_W     = 16;
   localparam int NUM_DIGITOS = 4;

   localparam logic [TECLA_W-1:0] TECLA_BORRAR = 4'hA;
   localparam logic [TECLA_W-1:0] TECLA_ENTER  = 4'hB;

   typedef enum logic [1:0] {
      ESPERA   = 2'd0,
      CAPTURA  = 2'd1,
      COMPLETA = 2'd2,
      ENTREGA  = 2'd3
   } estado_t;

   function automatic logic es_digito(input logic [TECLA_W-1:0] codigo);
      return (codigo <= 4'd9);
   endfunction

endpackage

// File: rtl/captura_clave_teclado_detector_flanco.sv
// Key press edge detector: one tecla_evento per rising edge of tecla_valida.
// Optional 2-flop input synchronizer enabled with macro TECLA_SYNC_EN.
module detector_flanco_tecla
   import captura_clave_teclado_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               tecla_valida,
   input  logic [TECLA_W-1:0] tecla_codigo,
   output logic               tecla_evento,
   output logic [TECLA_W-1:0] codigo_evento
);

   logic               valida_s;
   logic [TECLA_W-1:0] codigo_s;
   logic               tecla_prev;

`ifdef TECLA_SYNC_EN
   logic [1:0]         valida_sync;
   logic [TECLA_W-1:0] codigo_sync1;
   logic [TECLA_W-1:0] codigo_sync2;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valida_sync  <= '0;
         codigo_sync1 <= '0;
         codigo_sync2 <= '0;
      end else begin
         valida_sync  <= {valida_sync[0], tecla_valida};
         codigo_sync1 <= tecla_codigo;
         codigo_sync2 <= codigo_sync1;
      end
   end

   assign valida_s = valida_sync[1];
   assign codigo_s = codigo_sync2;
`else
   assign valida_s = tecla_valida;
   assign codigo_s = tecla_codigo;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) tecla_prev <= 1'b0;
      else       tecla_prev <= valida_s;
   end

   // Held keys keep valida_s high, so only the first cycle produces an event.
   assign tecla_evento  = valida_s & ~tecla_prev;
   assign codigo_evento = codigo_s;

endmodule

// File: rtl/captura_clave_teclado.sv
// Keypad PIN capture: assembles 4 BCD digits, delivers them on ENTER with a
// one-cycle clave_lista strobe, flags malformed or timed-out entries. Macro: TECLA_SYNC_EN.
module captura_clave_teclado
   import captura_clave_teclado_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = 1000,
   parameter int CNT_W          = 10
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               habilitar,
   input  logic               tecla_valida,
   input  logic [TECLA_W-1:0] tecla_codigo,
   output logic [CLAVE_W-1:0] clave_ingresada,
   output logic               clave_lista,
   output logic [2:0]         digitos,
   output logic               error_formato
);

   logic               tecla_evento;
   logic [TECLA_W-1:0] codigo_evento;

   estado_t            estado, estado_sig;
   logic [CLAVE_W-1:0] buffer, buffer_sig;
   logic [2:0]         digitos_sig;
   logic [CNT_W-1:0]   cnt, cnt_sig;
   logic [CLAVE_W-1:0] clave_sig;
   logic               lista_sig;
   logic               error_sig;

   logic               tecla_util;
   logic               cuenta_activa;
   logic               vencido;

   detector_flanco_tecla u_detector (
      .clock         (clock),
      .reset         (reset),
      .tecla_valida  (tecla_valida),
      .tecla_codigo  (tecla_codigo),
      .tecla_evento  (tecla_evento),
      .codigo_evento (codigo_evento)
   );

   // Codes 0xC-0xF are not "accepted": they neither act nor restart the timeout.
   assign tecla_util    = tecla_evento &&
                          (es_digito(codigo_evento) ||
                           codigo_evento == TECLA_BORRAR ||
                           codigo_evento == TECLA_ENTER);
   assign cuenta_activa = (estado == CAPTURA) || (estado == COMPLETA);
   assign vencido       = cuenta_activa && (cnt == CNT_W'(TIMEOUT_CICLOS - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado          <= ESPERA;
         buffer          <= '0;
         digitos         <= '0;
         cnt             <= '0;
         clave_ingresada <= '0;
         clave_lista     <= 1'b0;
         error_formato   <= 1'b0;
      end else begin
         estado          <= estado_sig;
         buffer          <= buffer_sig;
         digitos         <= digitos_sig;
         cnt             <= cnt_sig;
         clave_ingresada <= clave_sig;
         clave_lista     <= lista_sig;
         error_formato   <= error_sig;
      end
   end

   always_comb begin
      estado_sig  = estado;
      buffer_sig  = buffer;
      digitos_sig = digitos;
      cnt_sig     = cnt;
      if (!habilitar) begin
         estado_sig  = ESPERA;
         buffer_sig  = '0;
         digitos_sig = '0;
         cnt_sig     = '0;
      end else if (tecla_util) begin
         cnt_sig = '0;
         if (es_digito(codigo_evento)) begin
            if (estado != COMPLETA) begin
               buffer_sig  = {buffer[CLAVE_W-TECLA_W-1:0], codigo_evento};
               digitos_sig = digitos + 3'd1;
               estado_sig  = (digitos == 3'(NUM_DIGITOS - 1)) ? COMPLETA : CAPTURA;
            end
         end else begin
            // BORRAR and ENTER both empty the buffer; only ENTER in COMPLETA delivers.
            buffer_sig  = '0;
            digitos_sig = '0;
            estado_sig  = (codigo_evento == TECLA_ENTER && estado == COMPLETA) ? ENTREGA : ESPERA;
         end
      end else if (vencido) begin
         estado_sig  = ESPERA;
         buffer_sig  = '0;
         digitos_sig = '0;
         cnt_sig     = '0;
      end else if (estado == ENTREGA) begin
         estado_sig = ESPERA;
      end else if (cuenta_activa) begin
         cnt_sig = cnt + CNT_W'(1);
      end
   end

   always_comb begin
      clave_sig = clave_ingresada;
      lista_sig = 1'b0;
      error_sig = 1'b0;
      if (habilitar) begin
         if (tecla_util) begin
            if (es_digito(codigo_evento)) begin
               error_sig = (estado == COMPLETA);
            end else if (codigo_evento == TECLA_ENTER) begin
               if (estado == COMPLETA) begin
                  clave_sig = buffer;
                  lista_sig = 1'b1;
               end else begin
                  error_sig = 1'b1;
               end
            end
         end else if (vencido) begin
            error_sig = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_captura_clave_teclado.sv
// Directed self-checking bench for captura_clave_teclado (default build,
// inputs synchronous, TIMEOUT_CICLOS = 1000).
module tb_captura_clave_teclado;

   logic        clock;
   logic        reset;
   logic        habilitar;
   logic        tecla_valida;
   logic [3:0]  tecla_codigo;
   logic [15:0] clave_ingresada;
   logic        clave_lista;
   logic [2:0]  digitos;
   logic        error_formato;

   int checks = 0;
   int errors = 0;
   int n_lista = 0;
   int n_err = 0;
   logic [15:0] clave_entregada = '0;
   int l0, e0;

   captura_clave_teclado #(.TIMEOUT_CICLOS(1000), .CNT_W(10)) dut (
      .clock           (clock),
      .reset           (reset),
      .habilitar       (habilitar),
      .tecla_valida    (tecla_valida),
      .tecla_codigo    (tecla_codigo),
      .clave_ingresada (clave_ingresada),
      .clave_lista     (clave_lista),
      .digitos         (digitos),
      .error_formato   (error_formato)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Strobe counters sampled on the inactive edge.
   always @(negedge clock) begin
      if (clave_lista === 1'b1) begin
         n_lista++;
         clave_entregada = clave_ingresada;
      end
      if (error_formato === 1'b1) n_err++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Press a key for 'hold' cycles, check digitos right after the sampling edge, release.
   task automatic press(input logic [3:0] code, input int hold, input logic [2:0] exp_dig, input string tag);
      tecla_codigo = code;
      tecla_valida = 1'b1;
      tick(1);
      check(tag, digitos, exp_dig);
      if (hold > 1) tick(hold - 1);
      tecla_valida = 1'b0;
      tick(1);
   endtask

   initial begin
      reset        = 1'b1;
      habilitar    = 1'b0;
      tecla_valida = 1'b0;
      tecla_codigo = 4'h0;
      tick(2);
      check("reset clave", clave_ingresada, 16'h0000);
      check("reset lista", clave_lista, 1'b0);
      check("reset digitos", digitos, 3'd0);
      check("reset error", error_formato, 1'b0);
      reset     = 1'b0;
      habilitar = 1'b1;
      tick(1);

      // 1: plain 1234 delivery
      l0 = n_lista; e0 = n_err;
      press(4'h1, 3, 3'd1, "t1 dig1");
      press(4'h2, 3, 3'd2, "t1 dig2");
      press(4'h3, 3, 3'd3, "t1 dig3");
      press(4'h4, 3, 3'd4, "t1 dig4");
      tecla_codigo = 4'hB;
      tecla_valida = 1'b1;
      tick(1);
      check("t1 lista strobe", clave_lista, 1'b1);
      check("t1 clave", clave_ingresada, 16'h1234);
      check("t1 digitos after enter", digitos, 3'd0);
      tick(1);
      check("t1 lista one cycle", clave_lista, 1'b0);
      tick(1);
      tecla_valida = 1'b0;
      tick(1);
      check("t1 lista count", n_lista - l0, 1);
      check("t1 error count", n_err - e0, 0);

      // 2: long-held key counts once
      l0 = n_lista; e0 = n_err;
      press(4'h7, 20, 3'd1, "t2 dig7");
      check("t2 held key single", digitos, 3'd1);
      press(4'h0, 3, 3'd2, "t2 dig0a");
      press(4'h0, 3, 3'd3, "t2 dig0b");
      press(4'h1, 3, 3'd4, "t2 dig1");
      press(4'hB, 3, 3'd0, "t2 enter");
      check("t2 clave", clave_ingresada, 16'h7001);
      check("t2 delivered", clave_entregada, 16'h7001);
      check("t2 lista count", n_lista - l0, 1);
      check("t2 error count", n_err - e0, 0);

      // 3: premature ENTER
      l0 = n_lista; e0 = n_err;
      press(4'h5, 3, 3'd1, "t3 dig5");
      press(4'h6, 3, 3'd2, "t3 dig6");
      press(4'hB, 3, 3'd0, "t3 enter");
      check("t3 error count", n_err - e0, 1);
      check("t3 lista count", n_lista - l0, 0);
      check("t3 clave held", clave_ingresada, 16'h7001);

      // 4a: inter-key timeout
      e0 = n_err;
      press(4'h9, 3, 3'd1, "t4 dig9a");
      press(4'h9, 3, 3'd2, "t4 dig9b");
      tick(996);
      check("t4 before timeout digitos", digitos, 3'd2);
      check("t4 before timeout error", error_formato, 1'b0);
      tick(1);
      check("t4 timeout error", error_formato, 1'b1);
      check("t4 timeout digitos", digitos, 3'd0);
      tick(1);
      check("t4 timeout strobe one cycle", error_formato, 1'b0);
      check("t4 error count", n_err - e0, 1);

      // 4b: key in the timeout cycle wins
      e0 = n_err;
      press(4'h9, 3, 3'd1, "t4b dig9a");
      press(4'h9, 3, 3'd2, "t4b dig9b");
      tick(996);
      tecla_codigo = 4'h5;
      tecla_valida = 1'b1;
      tick(1);
      check("t4b key wins digitos", digitos, 3'd3);
      check("t4b key wins error", error_formato, 1'b0);
      tecla_valida = 1'b0;
      tick(1);
      press(4'hA, 3, 3'd0, "t4b borrar");
      check("t4b error count", n_err - e0, 0);

      // 5: habilitar drop discards partial entry silently; unused code ignored
      l0 = n_lista; e0 = n_err;
      press(4'h1, 3, 3'd1, "t5 dig1");
      press(4'h2, 3, 3'd2, "t5 dig2");
      press(4'h3, 3, 3'd3, "t5 dig3");
      habilitar = 1'b0;
      tick(1);
      check("t5 habilitar clears", digitos, 3'd0);
      habilitar = 1'b1;
      press(4'h4, 3, 3'd1, "t5 dig4");
      press(4'h3, 3, 3'd2, "t5 dig3b");
      press(4'hC, 3, 3'd2, "t5 unused code");
      press(4'h2, 3, 3'd3, "t5 dig2b");
      press(4'h1, 3, 3'd4, "t5 dig1b");
      press(4'hB, 3, 3'd0, "t5 enter");
      check("t5 clave", clave_ingresada, 16'h4321);
      check("t5 lista count", n_lista - l0, 1);
      check("t5 error count", n_err - e0, 0);

      // 6: fifth digit rejected, then async reset mid-entry
      l0 = n_lista; e0 = n_err;
      press(4'h1, 3, 3'd1, "t6 dig1");
      press(4'h2, 3, 3'd2, "t6 dig2");
      press(4'h3, 3, 3'd3, "t6 dig3");
      press(4'h4, 3, 3'd4, "t6 dig4");
      tecla_codigo = 4'h5;
      tecla_valida = 1'b1;
      tick(1);
      check("t6 fifth digit error", error_formato, 1'b1);
      check("t6 fifth digit digitos", digitos, 3'd4);
      tick(2);
      tecla_valida = 1'b0;
      tick(1);
      press(4'hB, 3, 3'd0, "t6 enter");
      check("t6 clave", clave_ingresada, 16'h1234);
      check("t6 lista count", n_lista - l0, 1);
      check("t6 error count", n_err - e0, 1);
      press(4'h6, 3, 3'd1, "t6 dig6");
      press(4'h7, 3, 3'd2, "t6 dig7");
      #2;
      reset = 1'b1;
      #1;
      check("t6 async reset clave", clave_ingresada, 16'h0000);
      check("t6 async reset digitos", digitos, 3'd0);
      check("t6 async reset lista", clave_lista, 1'b0);
      check("t6 async reset error", error_formato, 1'b0);
      tick(1);
      reset = 1'b0;
      tick(2);
      check("t6 after reset digitos", digitos, 3'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/captura_clave_teclado.md
Name: captura_clave_teclado

Overview:
Upstream stage of the parking access controller. Converts raw keypad events into the 16-bit BCD PIN that the access controller consumes on `clave_ingresada`, and qualifies each PIN with a one-cycle `clave_lista` strobe. Accepts keys only while a vehicle is present at the gate. Handles clear, enter, malformed entries and inter-key timeout, so the downstream controller only ever sees complete 4-digit PINs.

Parameters:
- `TIMEOUT_CICLOS`, default 1000: clock cycles allowed between accepted keys before a partial entry is discarded.
- `CNT_W`, default 10: width of the timeout counter; must satisfy 2^`CNT_W` >= `TIMEOUT_CICLOS`.

Ports:
- `clock`  in  1: single system clock, rising-edge.
- `reset`  in  1: asynchronous, active-high; clears all state.
- `habilitar`  in  1: high while a vehicle is at the gate; driven from the arrival sensor.
- `tecla_valida`  in  1: level from the keypad scanner, high while a key is held.
- `tecla_codigo`  in  4: key code. 0x0-0x9 are digits, 0xA is BORRAR, 0xB is ENTER, 0xC-0xF are unused.
- `clave_ingresada`  out  16: last delivered PIN, 4 BCD nibbles with the first-typed digit in [15:12].
- `clave_lista`  out  1: one-cycle strobe; `clave_ingresada` is valid in that cycle.
- `digitos`  out  3: number of digits currently buffered, 0-4.
- `error_formato`  out  1: one-cycle strobe flagging a discarded or malformed entry.

Behaviour:
- Clock and reset: one clock (`clock`); reset (`reset`) is asynchronous and active-high.
- Reset values: `clave_ingresada`=0, `clave_lista`=0, `digitos`=0, `error_formato`=0, internal buffer=0, state=ESPERA, timeout counter=0, `tecla_prev`=0.
- Key acceptance:
  - A key is accepted only on a rising edge of `tecla_valida` (`tecla_valida`=1 and `tecla_prev`=0).
  - Held keys produce exactly one event.
  - `tecla_codigo` is sampled in the same cycle as that edge.
- States:
  - ESPERA: 0 digits buffered.
  - CAPTURA: 1-3 digits buffered.
  - COMPLETA: 4 digits buffered, waiting for ENTER.
  - ENTREGA: single cycle, then ESPERA.
- Digit key (0x0-0x9):
  - In ESPERA or CAPTURA: buffer <= {buffer[11:0], codigo}; `digitos`+1. The 4th digit moves the FSM to COMPLETA.
  - In COMPLETA: the digit is ignored, buffer is kept, and `error_formato` pulses.
- BORRAR (0xA): from any active state, buffer=0, `digitos`=0, go to ESPERA. No error strobe.
- ENTER (0xB):
  - In COMPLETA: `clave_ingresada` <= buffer, go to ENTREGA. `clave_lista`=1 for exactly the cycle after the edge that sampled ENTER. Buffer and `digitos` clear in that same update.
  - In ESPERA or CAPTURA: buffer cleared, `error_formato` pulses, go to ESPERA.
- Codes 0xC-0xF: ignored entirely. They do not reset the timeout.
- `clave_ingresada` holds its value between deliveries. It changes only on delivery or reset.
- Timeout:
  - The counter runs only in CAPTURA and COMPLETA. It clears on every accepted key.
  - On reaching `TIMEOUT_CICLOS`-1: buffer cleared, `error_formato` pulses, go to ESPERA.
- `habilitar`=0:
  - The FSM is forced to ESPERA and buffer/`digitos`/counter are cleared. No error strobe.
  - All keys are ignored.
  - `clave_lista` is suppressed even if ENTREGA was pending.
- Priority within one cycle: `reset` > `habilitar`=0 > accepted key > timeout. A key arriving in the timeout cycle wins and restarts the counter.
- Latency:
  - A key edge sampled at clock edge k is reflected in `digitos` after edge k.
  - `error_formato` and `clave_lista` are registered: high from edge k to edge k+1.
- All outputs are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro: `TECLA_SYNC_EN`.
- Defined: `tecla_valida` and `tecla_codigo` pass through a 2-flop synchronizer (reset to 0) before edge detection. This adds 2 cycles of latency to every key response.
- Undefined: inputs are used directly; they are assumed synchronous to `clock`.

Decomposition:
- Shared package, used by both this block and the access controller:
  - `TECLA_BORRAR`=4'hA and `TECLA_ENTER`=4'hB.
  - `CLAVE_W`=16 and `NUM_DIGITOS`=4.
  - The state encoding (ESPERA, CAPTURA, COMPLETA, ENTREGA).
- One natural sub-module: `detector_flanco_tecla`. It holds the optional synchronizer plus the `tecla_prev` register and outputs a one-cycle `tecla_evento` with the captured code.

Test Plan:
1. `habilitar`=1; keys 1,2,3,4 then ENTER, each held 3 cycles -> `clave_lista`=1 for one cycle with `clave_ingresada`=16'h1234; `digitos` steps 1,2,3,4,0.
2. Key 7 held 20 cycles, then keys 0,0,1, ENTER -> exactly one 7 is captured; output 16'h7001.
3. Keys 5,6 then ENTER -> `error_formato` pulses once, `clave_lista` stays 0, `digitos`=0, `clave_ingresada` keeps its previous value.
4. Keys 9,9 then no key for `TIMEOUT_CICLOS` cycles -> `error_formato` pulses at cycle 999 after the last key; `digitos`=0. A key arriving exactly in that cycle instead gives `digitos`=3 and no error.
5. Keys 1,2,3; drop `habilitar` for 1 cycle; raise it; keys 4,3,2,1, ENTER -> no error strobe; output 16'h4321.
6. Keys 1,2,3,4,5 then ENTER -> the 5th key pulses `error_formato`; output 16'h1234. Asserting `reset` mid-entry clears all outputs to 0 immediately, without waiting for a clock edge.
